// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Holds the pipeline via stall_o until {remainder, quotient} is ready for HI/LO.
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  input  logic        annul_i,
  output logic        stall_o,
  output logic        ready_o,
  output logic [63:0] result_o,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DZERO = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [64:0] work;
  logic [64:0] work_step;
  logic [64:0] shifted;
  logic [33:0] diff;
  logic [31:0] divisor;
  logic [4:0]  count;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] q_fin;
  logic [31:0] r_fin;
  logic        load_op;
  logic        load_res;
  logic        load_zero;

  assign dbg_state = state;

  // Magnitudes only for DIV; 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  always_comb begin
    abs_a = opa_i;
    abs_b = opb_i;
    if (signed_i && opa_i[31]) abs_a = ~opa_i + 32'd1;
    if (signed_i && opb_i[31]) abs_b = ~opb_i + 32'd1;
  end

  // One restoring step: shift, trial-subtract from the 33-bit partial remainder, keep if non-negative.
  always_comb begin
    shifted   = {work[63:0], 1'b0};
    diff      = {1'b0, shifted[64:32]} - {2'b00, divisor};
    work_step = shifted;
    if (!diff[33]) work_step = {diff[32:0], shifted[31:1], 1'b1};
  end

  // Sign fix-up applied to the last step so result_o is final on the edge into DONE.
  always_comb begin
    q_fin = work_step[31:0];
    r_fin = work_step[63:32];
    if (neg_q) q_fin = ~work_step[31:0] + 32'd1;
    if (neg_r) r_fin = ~work_step[63:32] + 32'd1;
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    ready_o   = 1'b0;
    load_op   = 1'b0;
    load_res  = 1'b0;
    load_zero = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && !annul_i) begin
          stall_o = 1'b1;
          if (opb_i == 32'd0) begin
            state_nxt = DZERO;
          end else begin
            state_nxt = BUSY;
            load_op   = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (annul_i) begin
          state_nxt = IDLE;
        end else if (count == 5'd31) begin
          state_nxt = DONE;
          load_res  = 1'b1;
        end
      end
      DZERO: begin
        stall_o = 1'b1;
        if (annul_i) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
          load_zero = 1'b1;
        end
      end
      DONE: begin
        // start_i is still high here for the same instruction; never restart from DONE.
        ready_o   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      work     <= '0;
      divisor  <= '0;
      count    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
    end else begin
      if (load_op) begin
        work    <= {33'd0, abs_a};
        divisor <= abs_b;
        count   <= '0;
        neg_q   <= signed_i & (opa_i[31] ^ opb_i[31]);
        neg_r   <= signed_i & opa_i[31];
      end else if (state == BUSY) begin
        work  <= work_step;
        count <= count + 5'd1;
      end
      if (load_res) begin
        result_o <= {r_fin, q_fin};
      end else if (load_zero) begin
        result_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: per-cycle expectation queue built from a
// plain-arithmetic division model, plus literal checks on known results.
module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic        annul_i;
  logic        stall_o;
  logic        ready_o;
  logic [63:0] result_o;
  logic [1:0]  dbg_state;

  int          n_checks;
  int          n_errors;
  bit          chk_en;
  logic [63:0] held;
  logic [63:0] dut_last;
  logic [65:0] e;
  logic [65:0] exp_q[$];

  div_unit dut (
    .clk       (clk),
    .resetn    (resetn),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opa_i     (opa_i),
    .opb_i     (opb_i),
    .annul_i   (annul_i),
    .stall_o   (stall_o),
    .ready_o   (ready_o),
    .result_o  (result_o),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: 64-bit arithmetic, truncating division, remainder follows dividend.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint la, lb, q, r;
    if (b == 32'd0) return 64'h0;
    if (s) begin
      la = $signed({{32{a[31]}}, a});
      lb = $signed({{32{b[31]}}, b});
    end else begin
      la = $signed({32'd0, a});
      lb = $signed({32'd0, b});
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // compare process: one expectation per cycle, idle expectation when queue is empty
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = {2'b00, held};
      check("stall_o", {63'd0, stall_o}, {63'd0, e[65]});
      check("ready_o", {63'd0, ready_o}, {63'd0, e[64]});
      check("result_o", result_o, e[63:0]);
      if (ready_o) dut_last = result_o;
    end
  end

  // driver: start_i held from cycle 0 until the result cycle; optional annul/reset at cycle abort_k
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                         input int abort_k, input bit use_rst);
    logic [63:0] m;
    int lat;
    m   = model(a, b, s);
    lat = (b == 32'd0) ? 2 : 33;
    opa_i    = a;
    opb_i    = b;
    signed_i = s;
    start_i  = 1'b1;
    annul_i  = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      if (k == abort_k) begin
        if (use_rst) resetn = 1'b0;
        else annul_i = 1'b1;
        exp_q.push_back({(k != 0) || use_rst, 1'b0, held});
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        resetn  = 1'b1;
        start_i = 1'b0;
        if (use_rst) held = 64'h0;
        return;
      end
      if (k == lat) begin
        exp_q.push_back({1'b0, 1'b1, m});
      end else begin
        exp_q.push_back({1'b1, 1'b0, held});
      end
      @(posedge clk);
      #1;
      if (k == lat) held = m;
    end
  endtask

  task automatic idle(input int n);
    start_i = 1'b0;
    annul_i = 1'b0;
    opa_i   = $urandom;
    opb_i   = $urandom;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_op(input bit is_b);
    case ($urandom_range(0, 7))
      0: return is_b ? 32'd0 : 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return $urandom_range(1, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    chk_en   = 1'b0;
    held     = 64'h0;
    dut_last = 64'h0;
    resetn   = 1'b0;
    start_i  = 1'b0;
    signed_i = 1'b0;
    annul_i  = 1'b0;
    opa_i    = 32'd0;
    opb_i    = 32'd0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    resetn = 1'b1;
    idle(2);

    // model pinned by hand-computed values
    check("model_divu_100_7", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    check("model_div_m7_2", model(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    check("model_div_ovf", model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'd0, 32'h8000_0000});

    run_div(32'd100, 32'd7, 1'b0, -1, 1'b0);
    check("divu_100_7", dut_last, {32'd2, 32'd14});
    idle(1);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, -1, 1'b0);
    check("div_m7_2", dut_last, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    idle(2);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, -1, 1'b0);
    check("div_7_m2", dut_last, {32'h1, 32'hFFFF_FFFD});
    idle(1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, 1'b0);
    check("div_ovf", dut_last, {32'd0, 32'h8000_0000});
    idle(1);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, -1, 1'b0);
    check("divu_max_1", dut_last, {32'd0, 32'hFFFF_FFFF});
    idle(1);
    run_div(32'd1234, 32'd0, 1'b1, -1, 1'b0);
    check("div_by_zero", dut_last, 64'h0);
    idle(1);
    run_div(32'd1000, 32'd3, 1'b0, -1, 1'b0);
    check("divu_1000_3", dut_last, {32'd1, 32'd333});
    idle(1);
    run_div(32'd77, 32'd5, 1'b0, 10, 1'b0);
    idle(3);
    run_div(32'd77, 32'd5, 1'b0, 0, 1'b0);
    idle(2);
    run_div(32'd77, 32'd0, 1'b0, 1, 1'b0);
    idle(2);
    check("annul_keeps_result", dut_last, {32'd1, 32'd333});
    run_div(32'd99, 32'd4, 1'b1, 20, 1'b1);
    idle(3);
    run_div(32'd50, 32'd5, 1'b0, -1, 1'b0);
    check("b2b_first", dut_last, {32'd0, 32'd10});
    run_div(32'd9, 32'd4, 1'b0, -1, 1'b0);
    check("b2b_second", dut_last, {32'd1, 32'd2});
    idle(2);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      int ab;
      a  = rand_op(1'b0);
      b  = rand_op(1'b1);
      ab = -1;
      if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, (b == 32'd0) ? 1 : 32);
      run_div(a, b, 1'($urandom_range(0, 1)), ab, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the execute stage of the 5-stage MIPS pipeline, serving DIV/DIVU. While a division is in flight it raises a stall request that the hazard unit ORs into stallF/stallD/stallE. The stall holds the divide instruction in E until the quotient and remainder are ready for the HI/LO write path. The divider uses a radix-2 restoring algorithm that produces one quotient bit per cycle.

## Interface
Parameters:
- none; the datapath width is fixed at 32.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- resetn  in  1  synchronous, active-low reset
- start_i  in  1  E-stage instruction is DIV/DIVU (level; held high by the stall while the instruction sits in E)
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i in IDLE
- opa_i  in  32  dividend (forwarded rs value from E)
- opb_i  in  32  divisor (forwarded rt value from E)
- annul_i  in  1  cancel any in-flight operation (exception/flushE)
- stall_o  out  1  divider busy; request to the hazard unit to stall F/D/E
- ready_o  out  1  one-cycle pulse: result_o valid this cycle
- result_o  out  64  {remainder[63:32] → HI, quotient[31:0] → LO}

## Operation
- States: IDLE, DZERO, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - annul_i=1: stay in IDLE. annul_i has priority over start_i.
  - start_i=1 and opb_i==0: go to DZERO.
  - start_i=1 and opb_i!=0: go to BUSY. On the same edge, latch |opa|, |opb| (absolute values only when signed_i=1), the negate-quotient flag (sign(a)^sign(b)) and the negate-remainder flag (sign(a)). Clear the 5-bit counter.
- BUSY:
  - Work register is 65 bits: {partial remainder[32:0], quotient[31:0]}.
  - Each cycle: shift left 1, trial-subtract the 33-bit zero-extended divisor from the upper 33 bits.
  - If the difference is non-negative, replace the upper 33 bits with it and set the LSB to 1.
  - Increment the counter. When counter==31 at the edge, go to DONE.
- DZERO: one cycle, then go to DONE with the result forced to 64'h0.
- DONE:
  - result_o is loaded with the final value, after conditional negation of quotient and remainder.
  - ready_o=1 and stall_o=0.
  - Return to IDLE unconditionally. start_i in DONE belongs to the same instruction and must not restart the divider.
- annul_i=1 in BUSY/DZERO/DONE: go to IDLE on the next edge. No ready_o pulse in the following cycle; result_o keeps its previous value.
- stall_o = (IDLE & start_i & ~annul_i) | BUSY | DZERO. It is combinational, so the first stall cycle is the cycle start_i is first seen.
- Arithmetic:
  - Signed 0x80000000 / 0xFFFFFFFF yields q=0x80000000, r=0 (natural 32-bit wrap of the negation).
  - Remainder sign follows the dividend; quotient truncates toward zero.

## Timing
- Reset values: stall_o=0, ready_o=0, result_o=64'h0, counter=0, state=IDLE.
- Latency, nonzero divisor:
  - start_i first seen in cycle 0.
  - BUSY for cycles 1–32.
  - DONE in cycle 33: ready_o=1, stall_o=0.
  - The instruction leaves E at the end of cycle 33.
- Latency, divisor zero: DZERO in cycle 1, DONE in cycle 2.
- Back-to-back divides: the second DIV enters E at the edge closing DONE and is seen in IDLE in the next cycle, with no bubble lost.
- result_o is registered. It changes only on entry to DONE and is held afterwards.
- resetn=0 mid-operation: all state returns to reset values on that edge. No ready_o pulse follows.

## Test plan
- DIVU 100/7, start_i held until ready: stall_o high in cycles 0–32, ready_o pulse in cycle 33, result_o=={32'd2, 32'd14}.
- DIV −7/2 (0xFFFFFFF9 / 0x2): result_o=={32'hFFFFFFFF, 32'hFFFFFFFD}. Also DIV 7/−2 gives {32'h1, 32'hFFFFFFFD}.
- DIV 0x80000000/0xFFFFFFFF gives {0, 32'h80000000}. DIVU 0xFFFFFFFF/1 gives {0, 32'hFFFFFFFF}.
- Divide by zero, opb_i=0: stall_o high in cycles 0–1, ready_o in cycle 2, result_o==64'h0.
- annul_i pulsed in cycle 10: state IDLE next cycle, stall_o=0, no ready_o, result_o unchanged. Repeat with resetn=0 in cycle 20: all outputs return to reset values.
- Two DIVU back-to-back (50/5 then 9/4): ready_o pulses in cycles 33 and 67, results {0,10} and {1,2}. No spurious restart in either DONE cycle.
